// File: rtl/gf128_mul_digit_if.sv
// Operand/result bus of the digit-serial GF(2^128) multiplier.
//
// Handshake: an operand transfers on a rising clock edge where
// iData_valid && oData_ready are both high; iData and iAcc are sampled only
// then. The master may raise iData_valid at any time and must hold it, with
// stable iData/iAcc, until the transfer edge. oResult_valid is a one-cycle
// pulse that has no back-pressure. iClr and iHashkey_load are plain
// strobes that are honoured whenever the block is not multiplying.
interface gf128_mul_digit_if;
    logic [127:0] iData;
    logic         iData_valid;
    logic         oData_ready;
    logic         iAcc;
    logic         iClr;
    logic [127:0] iHashkey;
    logic         iHashkey_load;
    logic [127:0] oResult;
    logic         oResult_valid;
    logic         oBusy;

    modport master (
        output iData, iData_valid, iAcc, iClr, iHashkey, iHashkey_load,
        input  oData_ready, oResult, oResult_valid, oBusy
    );

    modport slave (
        input  iData, iData_valid, iAcc, iClr, iHashkey, iHashkey_load,
        output oData_ready, oResult, oResult_valid, oBusy
    );
endinterface

// File: rtl/gf128_mul_digit.sv
// Digit-serial GF(2^128) multiplier for GHASH. Processes DIGIT operand bits
// per clock with the right-shift algorithm, so one product takes
// 128/DIGIT cycles. Optional accumulate mode computes (X ^ Y) * H.
// All 128-bit values use GCM bit order: bit [127] is the x^0 coefficient.
module gf128_mul_digit #(
    parameter int DIGIT = 8
) (
    input  logic               iClk,
    input  logic               iRst_n,
    gf128_mul_digit_if.slave   bus,
    output logic [1:0]         oDbg_state
);

    localparam int NCYC  = 128 / DIGIT;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);
    // Reduction constant 11100001 || 0^120 in GCM order.
    localparam logic [127:0] R_POLY = {8'hE1, 120'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       h_q, h_d;
    logic [127:0]       z_q, z_d;
    logic [127:0]       v_q, v_d;
    logic [127:0]       a_q, a_d;
    logic [127:0]       result_q, result_d;

    logic [127:0]       z_step, v_step, a_step;
    logic               v_lsb;
    logic               accept;
    logic [127:0]       acc_base;

    // DIGIT iterations of the right-shift multiply; A is shifted left so that
    // a_q[127] is always the next field bit to consume.
    always_comb begin
        z_step = z_q;
        v_step = v_q;
        a_step = a_q;
        v_lsb  = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (a_step[127]) begin
                z_step = z_step ^ v_step;
            end
            a_step = a_step << 1;
            v_lsb  = v_step[0];
            v_step = (v_step >> 1) ^ (v_lsb ? R_POLY : 128'b0);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        z_d      = z_q;
        v_d      = v_q;
        a_d      = a_q;
        result_d = result_q;
        accept   = 1'b0;
        acc_base = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Clear beats the result already sitting in DONE, and also
                // feeds zero into an accumulate accepted in the same cycle.
                if (bus.iClr) begin
                    result_d = 128'b0;
                    acc_base = 128'b0;
                end
                if (bus.iHashkey_load) begin
                    h_d = bus.iHashkey;
                end
                accept = bus.iData_valid;
                if (accept) begin
                    a_d     = bus.iAcc ? (bus.iData ^ acc_base) : bus.iData;
                    z_d     = 128'b0;
                    // A key loaded alongside the operand is used immediately.
                    v_d     = bus.iHashkey_load ? bus.iHashkey : h_q;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                z_d   = z_step;
                v_d   = v_step;
                a_d   = a_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = z_step;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any product in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            h_q      <= 128'b0;
            z_q      <= 128'b0;
            v_q      <= 128'b0;
            a_q      <= 128'b0;
            result_q <= 128'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            h_q      <= h_d;
            z_q      <= z_d;
            v_q      <= v_d;
            a_q      <= a_d;
            result_q <= result_d;
        end
    end

    // Ready is masked by reset so nothing is offered while reset is held.
    assign bus.oData_ready   = iRst_n && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign bus.oBusy         = (state_q == ST_RUN);
    assign bus.oResult_valid = (state_q == ST_DONE);
    assign bus.oResult       = result_q;
    assign oDbg_state        = state_q;

endmodule

// File: tb/tb_gf128_mul_digit.sv
// Bench for gf128_mul_digit: directed GCM vectors plus randomized operands
// checked against a polynomial-arithmetic GF(2^128) model.
module tb_gf128_mul_digit;

    parameter int DIGIT = 8;
    localparam int N = 128 / DIGIT;

    localparam logic [127:0] H_ONE  = 128'h80000000_00000000_00000000_00000000;
    localparam logic [127:0] X_ID   = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] H_TC2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] Y_TC2  = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] X_LEN  = 128'h00000000000000000000000000000080;
    localparam logic [127:0] Y_ACC  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    gf128_mul_digit_if ifc();

    gf128_mul_digit #(.DIGIT(DIGIT)) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .bus        (ifc),
        .oDbg_state (dbg_state)
    );

    int n_cmp;
    int n_err;

    // Reference model state.
    logic [127:0] m_h;
    logic [127:0] m_res;
    logic [127:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [127:0] brev(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = v[127-i];
        return r;
    endfunction

    // Plain carry-less polynomial product, then reduction by
    // x^128 + x^7 + x^2 + x + 1, working in natural (bit k = x^k) order.
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] p;
        logic [127:0] ra, rb;
        ra = brev(a);
        rb = brev(b);
        p  = '0;
        for (int i = 0; i < 128; i++)
            if (ra[i]) p = p ^ ({128'b0, rb} << i);
        for (int k = 254; k >= 128; k--)
            if (p[k]) p = p ^ (256'd1 << k) ^ ({248'b0, 8'h87} << (k - 128));
        return brev(p[127:0]);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ifc.iData         = '0;
        ifc.iData_valid   = 1'b0;
        ifc.iAcc          = 1'b0;
        ifc.iClr          = 1'b0;
        ifc.iHashkey      = '0;
        ifc.iHashkey_load = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ifc.oData_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (ifc.oData_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready_timeout: got ready=%b want 1", name, ifc.oData_ready);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        wait_ready("load_key");
        ifc.iHashkey      = key;
        ifc.iHashkey_load = 1'b1;
        m_h = key;
        @(posedge clk);
        #1;
        ifc.iHashkey_load = 1'b0;
        ifc.iHashkey      = rand128();
    endtask

    // One full operation: accept, wait for the pulse, check latency, result,
    // pulse width and hold. poke strobes load/clear mid-RUN; clr_done clears
    // in the DONE cycle.
    task automatic send_op(input logic [127:0] x, input logic acc, input logic clr,
                           input logic ld, input logic [127:0] key,
                           input logic poke, input logic clr_done, input string name);
        int lat;
        logic [127:0] a;
        logic [127:0] expv;
        wait_ready(name);
        ifc.iData         = x;
        ifc.iData_valid   = 1'b1;
        ifc.iAcc          = acc;
        ifc.iClr          = clr;
        ifc.iHashkey_load = ld;
        ifc.iHashkey      = key;
        if (ld) m_h = key;
        a    = acc ? (x ^ (clr ? 128'b0 : m_res)) : x;
        expv = gf_mul(a, m_h);
        @(posedge clk);
        #1;
        ifc.iData_valid   = 1'b0;
        ifc.iAcc          = 1'b0;
        ifc.iClr          = 1'b0;
        ifc.iHashkey_load = 1'b0;
        ifc.iData         = rand128();
        ifc.iHashkey      = rand128();
        lat = 0;
        @(negedge clk);
        while (!ifc.oResult_valid && lat < 400) begin
            n_cmp++;
            if ({ifc.oData_ready, ifc.oBusy} !== 2'b01) begin
                n_err++;
                $display("FAIL %s_run_flags: got ready/busy=%b want 01", name, {ifc.oData_ready, ifc.oBusy});
            end
            if (poke && lat == N / 2) begin
                ifc.iHashkey_load = 1'b1;
                ifc.iClr          = 1'b1;
            end else begin
                ifc.iHashkey_load = 1'b0;
                ifc.iClr          = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        ifc.iHashkey_load = 1'b0;
        ifc.iClr          = 1'b0;
        n_cmp++;
        if (lat !== N) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
        end
        n_cmp++;
        if (ifc.oResult !== expv) begin
            n_err++;
            $display("FAIL %s_result: got %h want %h", name, ifc.oResult, expv);
        end
        if (clr_done) begin
            ifc.iClr = 1'b1;
            @(posedge clk);
            #1;
            ifc.iClr = 1'b0;
            m_res = '0;
        end else begin
            m_res = expv;
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.oResult_valid, ifc.oResult} !== {1'b0, m_res}) begin
            n_err++;
            $display("FAIL %s_after_pulse: got valid=%b res=%h want valid=0 res=%h",
                     name, ifc.oResult_valid, ifc.oResult, m_res);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ifc.oData_ready, ifc.oResult_valid, ifc.oBusy, ifc.oResult} !== 131'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%h want all 0",
                     ifc.oData_ready, ifc.oResult_valid, ifc.oBusy, ifc.oResult);
        end
        rst_n = 1'b1;
        m_h   = '0;
        m_res = '0;
        @(negedge clk);
        n_cmp++;
        if ({ifc.oData_ready, ifc.oResult_valid, ifc.oBusy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: got rdy/vld/busy=%b want 100",
                     {ifc.oData_ready, ifc.oResult_valid, ifc.oBusy});
        end
    endtask

    task automatic test_identity();
        load_key(H_ONE);
        send_op(X_ID, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "identity");
        n_cmp++;
        if (ifc.oResult !== X_ID) begin
            n_err++;
            $display("FAIL identity_const: got %h want %h", ifc.oResult, X_ID);
        end
    endtask

    task automatic test_gcm_vectors();
        load_key(H_TC2);
        send_op(X_TC2, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "tc2");
        n_cmp++;
        if (ifc.oResult !== Y_TC2) begin
            n_err++;
            $display("FAIL tc2_const: got %h want %h", ifc.oResult, Y_TC2);
        end
        send_op(X_LEN, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "accumulate");
        n_cmp++;
        if (ifc.oResult !== Y_ACC) begin
            n_err++;
            $display("FAIL accumulate_const: got %h want %h", ifc.oResult, Y_ACC);
        end
    endtask

    task automatic test_mid_run_ignored();
        send_op(X_TC2, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "mid_run");
        n_cmp++;
        if (ifc.oResult !== Y_TC2) begin
            n_err++;
            $display("FAIL mid_run_const: got %h want %h", ifc.oResult, Y_TC2);
        end
        // Key must still be the old H: rerun with the clear in DONE.
        send_op(X_TC2, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, "clr_done");
        n_cmp++;
        if (ifc.oResult !== 128'b0) begin
            n_err++;
            $display("FAIL clr_done_zero: got %h want 0", ifc.oResult);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            logic acc, clr, ld;
            acc = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            ld  = ($urandom_range(0, 2) == 0);
            send_op(rand128(), acc, clr, ld, rand128(), 1'($urandom_range(0, 1)), 1'b0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ops[3];
        logic         accs[3];
        int           pulse_cyc[3];
        int           idx, pulses, cyc;
        logic         acc_now;
        logic [127:0] a;
        for (int i = 0; i < 3; i++) begin
            ops[i]  = rand128();
            accs[i] = (i != 0);
        end
        exp_q.delete();
        wait_ready("b2b");
        idx = 0; pulses = 0; cyc = 0;
        ifc.iData       = ops[0];
        ifc.iAcc        = accs[0];
        ifc.iData_valid = 1'b1;
        while (pulses < 3 && cyc < 1000) begin
            acc_now = ifc.oData_ready && ifc.iData_valid;
            if (acc_now) begin
                a     = accs[idx] ? (ops[idx] ^ m_res) : ops[idx];
                m_res = gf_mul(a, m_h);
                exp_q.push_back(m_res);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    ifc.iData = ops[idx];
                    ifc.iAcc  = accs[idx];
                end else begin
                    ifc.iData_valid = 1'b0;
                    ifc.iAcc        = 1'b0;
                end
            end
            if (ifc.oBusy) begin
                n_cmp++;
                if (ifc.oData_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_ready_in_run: got %b want 0", ifc.oData_ready);
                end
            end
            if (ifc.oResult_valid) begin
                pulse_cyc[pulses] = cyc;
                pulses++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected_pulse: got pulse at cycle %0d want none", cyc);
                end else begin
                    a = exp_q.pop_front();
                    if (ifc.oResult !== a) begin
                        n_err++;
                        $display("FAIL b2b_result: got %h want %h", ifc.oResult, a);
                    end
                end
            end
        end
        ifc.iData_valid = 1'b0;
        n_cmp++;
        if (pulses !== 3) begin
            n_err++;
            $display("FAIL b2b_pulse_count: got %0d want 3", pulses);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (pulse_cyc[i] - pulse_cyc[i-1] !== N + 1) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d want %0d", pulse_cyc[i] - pulse_cyc[i-1], N + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        wait_ready("rst_mid");
        ifc.iData       = rand128();
        ifc.iData_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.iData_valid = 1'b0;
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ifc.oData_ready, ifc.oResult_valid, ifc.oBusy, ifc.oResult} !== 131'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got rdy=%b vld=%b busy=%b res=%h want all 0",
                     ifc.oData_ready, ifc.oResult_valid, ifc.oBusy, ifc.oResult);
        end
        m_h   = '0;
        m_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ifc.oResult_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_no_pulse: got valid=%b want 0", ifc.oResult_valid);
            end
        end
        load_key(H_TC2);
        send_op(X_TC2, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "rst_mid_tc2");
        n_cmp++;
        if (ifc.oResult !== Y_TC2) begin
            n_err++;
            $display("FAIL rst_mid_tc2_const: got %h want %h", ifc.oResult, Y_TC2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        m_h   = '0;
        m_res = '0;
        test_reset();
        test_identity();
        test_gcm_vectors();
        test_mid_run_ignored();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish before limit");
        $fatal(1, "time limit");
    end

endmodule
